cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- miss_detected  input  1  cache miss reported by the IF or MEM stage
- miss_address  input  16  byte address that missed
- memory_data_valid  input  1  memory returns one word this cycle
- memory_data  input  16  returned word
- fsm_busy  output  1  fill in progress; the pipeline stalls while high
- memory_read  output  1  read request to memory this cycle
- memory_address  output  16  word address of the request
- write_data_array  output  1  write memory_data into the cache data array
- data_word_index  output  3  word slot within the block for that write
- write_tag_array  output  1  one-cycle pulse that writes the tag and valid bit
- fill_base  output  16  aligned block base of the current fill
REQ-002 The block SHALL use one clock (clk) and a synchronous, active-low reset (rst_n).

Function
REQ-003 A block SHALL be 16 bytes, or 8 words of 16 bits; fill_base SHALL equal miss_address with bits [3:0] cleared.
REQ-004 The state machine SHALL have two states: IDLE and FILL.
REQ-005 In IDLE:
- fsm_busy, memory_read, write_data_array and write_tag_array SHALL be 0.
- When miss_detected=1 at a rising edge, the block SHALL latch fill_base, clear both counters and enter FILL.
REQ-006 In FILL:
- fsm_busy SHALL be 1.
- miss_detected SHALL be ignored.
REQ-007 Issue side:
- A 4-bit issue counter, ic = 0..8, SHALL drive memory_read = (ic<8).
- memory_address SHALL be fill_base + 2*ic.
- ic SHALL increment each FILL cycle while ic<8.
- Requests SHALL therefore go out on 8 consecutive cycles, starting the first FILL cycle.
REQ-008 Receive side:
- A 4-bit receive counter rc SHALL advance by one on each memory_data_valid=1 cycle in FILL.
- write_data_array SHALL equal memory_data_valid in FILL.
- data_word_index SHALL equal rc[2:0].
REQ-009 The block SHALL NOT assume any memory latency; only memory_data_valid advances rc.
REQ-010 On the valid beat with rc=7, write_tag_array SHALL pulse high in that same cycle, and the state SHALL return to IDLE at the next edge.
REQ-011 memory_data_valid while in IDLE SHALL be ignored: no array write and no counter change.
REQ-012 The block SHALL NOT accept a new miss in the cycle it returns to IDLE; a miss held high SHALL start a new fill one cycle after fsm_busy falls.
REQ-013 In IDLE, memory_address SHALL hold fill_base and data_word_index SHALL read 0.
REQ-014 Address arithmetic SHALL be 16-bit. Aligned bases cannot wrap; a base of 0xFFF0 SHALL issue addresses up to 0xFFFE.

Reset
REQ-015 When rst_n=0 at a rising edge:
- state SHALL become IDLE; ic, rc and fill_base SHALL become 0.
- All outputs SHALL be 0 in the following cycle.
REQ-016 Reset mid-fill SHALL abandon the fill:
- No write_tag_array pulse SHALL occur.
- Late memory_data_valid beats after reset SHALL be ignored under REQ-011.
REQ-017 Reset SHALL take priority over miss_detected in the same cycle.

Structure
REQ-018 A shared package SHALL hold:
- the state encoding (IDLE=0, FILL=1)
- WORDS_PER_BLOCK=8
- BLOCK_OFFSET_BITS=4
- WORD_BYTES=2
REQ-019 One sub-module, fill_counter (4-bit, synchronous clear, enable, terminal-count output), SHALL be instantiated twice: once for ic and once for rc.
REQ-020 Outputs SHALL be combinational from state and counter registers only.
REQ-021 The block SHALL contain no memory model; the memory used for testing lives in the bench.

Verification
REQ-022 Basic fill:
- Stimulus: miss_address=0x1236 at cycle 0; the bench memory returns data 4 cycles after each request.
- Required response: memory_address = 0x1230..0x123E in cycles 1-8; write_data_array in cycles 5-12 with data_word_index 0..7; write_tag_array in cycle 12 only; fsm_busy high in cycles 1-12.
REQ-023 Irregular returns:
- Stimulus: valid beats with gaps (pattern 1,0,1,1,0,...).
- Required response: data_word_index increments only on valid beats; tag written exactly once, on the 8th beat.
REQ-024 Top-of-memory fill:
- Stimulus: miss_address=0xFFFF.
- Required response: fill_base=0xFFF0; last request is 0xFFFE.
REQ-025 Miss during fill:
- Stimulus: miss_detected pulses during FILL, then is held high after the fill.
- Required response: no disturbance to the current fill; the second fill starts one cycle after fsm_busy falls.
REQ-026 Reset during fill:
- Stimulus: rst_n=0 in cycle 6 of a fill, then 3 further valid beats.
- Required response: outputs 0 from cycle 7; no write_tag_array; no write_data_array for the late beats.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache line fill sequencer.
//   fill_state_t      : FSM state encoding (IDLE=0, FILL=1)
//   WORDS_PER_BLOCK   : 16-bit words per cache block
//   BLOCK_OFFSET_BITS : byte-offset bits inside a block
//   WORD_BYTES        : bytes per memory word
//   block_base()      : clears the block offset of a byte address
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_BYTES        = 2;
  localparam int COUNT_W           = 4;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return {addr[15:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// fill_counter: 4-bit up counter with synchronous clear and enable.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count up by one
//   count      : current value
//   tc         : high while count equals TERMINAL
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter logic [COUNT_W-1:0] TERMINAL = COUNT_W'(WORDS_PER_BLOCK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               tc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + COUNT_W'(1);
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one 16-byte block (8 x 16-bit words) on a miss.
//   clk, rst_n        : clock, synchronous active-low reset
//   miss_detected     : miss from the IF/MEM stage, sampled only in IDLE
//   miss_address      : byte address that missed
//   memory_data_valid : one returned word this cycle
//   memory_data       : returned word (routed to the data array outside)
//   fsm_busy          : fill in progress, pipeline stalls
//   memory_read       : read request this cycle
//   memory_address    : word address of the request (fill_base in IDLE)
//   write_data_array  : write memory_data into slot data_word_index
//   data_word_index   : word slot within the block (0 in IDLE)
//   write_tag_array   : one-cycle tag/valid write on the last beat
//   fill_base         : block-aligned base of the current fill
//
// Memory handshake: memory_read is a request with no back-pressure; memory
// answers every request exactly once, in order, with a memory_data_valid
// beat after any latency. Only those beats advance the receive side.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  data_word_index,
  output logic        write_tag_array,
  output logic [15:0] fill_base
);

  fill_state_t        state, state_next;
  logic [COUNT_W-1:0] ic, rc;
  logic               ic_tc, rc_tc;
  logic               ic_en, rc_en, start_fill;

  // The returned word goes straight to the data array; this block only
  // sequences the write, and rc[3] is never needed for the slot index.
  logic unused_inputs;
  assign unused_inputs = ^{memory_data, rc[3]};

  // Issue counter stops at 8 (all requests out).
  fill_counter #(.TERMINAL(COUNT_W'(WORDS_PER_BLOCK))) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .en    (ic_en),
    .count (ic),
    .tc    (ic_tc)
  );

  // Receive counter terminal is 7: the beat that lands on it is the last.
  fill_counter #(.TERMINAL(COUNT_W'(WORDS_PER_BLOCK - 1))) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .en    (rc_en),
    .count (rc),
    .tc    (rc_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_base <= '0;
    end else begin
      state <= state_next;
      if (start_fill) begin
        fill_base <= block_base(miss_address);
      end
    end
  end

  always_comb begin
    state_next       = state;
    start_fill       = 1'b0;
    ic_en            = 1'b0;
    rc_en            = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = fill_base;
    write_data_array = 1'b0;
    data_word_index  = 3'd0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          start_fill = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        memory_read      = !ic_tc;
        ic_en            = !ic_tc;
        memory_address   = fill_base + 16'(ic) * 16'(WORD_BYTES);
        write_data_array = memory_data_valid;
        rc_en            = memory_data_valid;
        data_word_index  = rc[2:0];
        if (memory_data_valid && rc_tc) begin
          write_tag_array = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_base;
  logic [2:0]  data_word_index;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_index   (data_word_index),
    .write_tag_array   (write_tag_array),
    .fill_base         (fill_base)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_addr_q[$];  // expected request addresses, in order
  logic [15:0] exp_base_q[$];  // expected fill_base at each tag write
  logic [4:0]  exp_wr_q[$];    // {write, tag, slot} for each live beat
  int fills_expected = 0;
  int tag_cnt = 0;

  // bench memory: one entry per captured request
  int          due_q[$];
  bit          live_q[$];
  int          lat_min = 4;
  int          lat_max = 4;
  int          gap_mode = 0;
  int          gap_pos = 0;
  logic [4:0]  gap_pat = 5'b01101;  // beats allowed: 1,0,1,1,0
  int          beat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (memory_read) begin
      due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      live_q.push_back(1'b1);
      if (exp_addr_q.size() == 0) note_fail("unexpected_read");
      else check("req_addr", 32'(memory_address), 32'(exp_addr_q.pop_front()));
    end
    if (write_data_array || write_tag_array) begin
      if (write_tag_array) begin
        tag_cnt++;
        if (exp_base_q.size() == 0) note_fail("unexpected_tag");
        else check("tag_base", 32'(fill_base), 32'(exp_base_q.pop_front()));
      end
      if (exp_wr_q.size() == 0) note_fail("unexpected_write");
      else check("write_slot", 32'({write_data_array, write_tag_array, data_word_index}),
                 32'(exp_wr_q.pop_front()));
    end else if (exp_wr_q.size() != 0) begin
      note_fail("missing_write");
      exp_wr_q.delete(0);
    end
  end

  // ---------------- memory driver + reference model ----------------
  // A reset seen at the last edge abandons every outstanding expectation;
  // beats still in flight become stale and must not be written.
  always @(posedge clk) begin
    bit ok;
    #1;
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_base_q.delete();
      exp_wr_q.delete();
      foreach (live_q[i]) live_q[i] = 1'b0;
      beat = 0;
    end
    case (gap_mode)
      1:       ok = gap_pat[gap_pos % 5];
      2:       ok = ($urandom_range(0, 2) != 0);
      default: ok = 1'b1;
    endcase
    gap_pos++;
    memory_data_valid = 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc && ok) begin
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
      if (live_q[0]) begin
        exp_wr_q.push_back({1'b1, beat == 7, 3'(beat)});
        beat = (beat + 1) % 8;
      end
      due_q.delete(0);
      live_q.delete(0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fill(input logic [15:0] a);
    logic [15:0] base;
    base = a & 16'hFFF0;
    exp_base_q.push_back(base);
    for (int k = 0; k < 8; k++) exp_addr_q.push_back(base + 16'(2 * k));
    fills_expected++;
  endtask

  task automatic start_miss(input logic [15:0] a, output int c0);
    @(posedge clk); #2;
    miss_detected = 1'b1;
    miss_address = a;
    c0 = cyc;
    push_fill(a);
    @(posedge clk); #2;
    miss_detected = 1'b0;
    miss_address = 16'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    @(negedge clk);
    while ((fsm_busy || due_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) note_fail("wait_done_timeout");
    @(negedge clk);
    check("tag_count", 32'(tag_cnt), 32'(fills_expected));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 32'({fsm_busy, memory_read, write_data_array, write_tag_array, data_word_index}), 32'd0);
    check({name, "_addr"}, {memory_address, fill_base}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    int k;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // basic fill, fixed latency 4
    lat_min = 4; lat_max = 4; gap_mode = 0;
    start_miss(16'h1236, c0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      k = cyc - c0;
      check($sformatf("basic_busy_c%0d", k), 32'(fsm_busy), 32'(k >= 1 && k <= 12));
      check($sformatf("basic_read_c%0d", k), 32'(memory_read), 32'(k >= 1 && k <= 8));
      check($sformatf("basic_wda_c%0d", k), 32'(write_data_array), 32'(k >= 5 && k <= 12));
      check($sformatf("basic_tag_c%0d", k), 32'(write_tag_array), 32'(k == 12));
      if (k >= 5 && k <= 12) check($sformatf("basic_idx_c%0d", k), 32'(data_word_index), 32'(k - 5));
    end
    wait_done(50);

    // irregular returns
    lat_min = 1; lat_max = 1; gap_mode = 1; gap_pos = 0;
    start_miss(16'($urandom), c0);
    wait_done(100);

    // top of memory
    lat_min = 2; lat_max = 2; gap_mode = 0;
    start_miss(16'hFFFF, c0);
    @(negedge clk);
    check("top_fill_base", 32'(fill_base), 32'h0000FFF0);
    wait_done(60);

    // miss pulses during a fill, then held high
    lat_min = 3; lat_max = 3; gap_mode = 2;
    start_miss(16'h4A52, c0);
    @(posedge clk); #2;
    @(posedge clk); #2; miss_detected = 1'b1; miss_address = 16'h9990;
    @(posedge clk); #2; miss_detected = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2; miss_detected = 1'b1; miss_address = 16'h7771;
    @(posedge clk); #2; miss_detected = 1'b0;
    @(posedge clk); #2; miss_detected = 1'b1; miss_address = 16'h2C6D;
    push_fill(16'h2C6D);
    n = 0;
    @(negedge clk);
    while (fsm_busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) note_fail("refill_busy_timeout");
    @(negedge clk);
    check("refill_start", 32'(fsm_busy), 32'd1);
    @(posedge clk); #2; miss_detected = 1'b0;
    wait_done(200);

    // reset in cycle 6 of a fill
    lat_min = 4; lat_max = 4; gap_mode = 0;
    start_miss(16'($urandom), c0);
    while (cyc < c0 + 6) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    fills_expected--;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all_zero($sformatf("midreset_c%0d", cyc - c0));
    end
    wait_done(50);

    // randomized fills
    lat_min = 1; lat_max = 6; gap_mode = 2;
    for (int f = 0; f < 8; f++) begin
      start_miss(16'($urandom), c0);
      wait_done(300);
    end

    check("exp_addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);
    check("exp_base_left", 32'(exp_base_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
